// File: rtl/packet_serializer.sv
// packet_serializer
// Takes a parallel payload and sends it one bit per symbol period to the BPSK
// modulator. An alternating 1/0 preamble goes out first so the far-end
// demodulator can lock. Then the payload follows, MSB first. A one-cycle done
// pulse follows the last payload symbol so the source can supply the next packet.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   packet     payload, sampled only when load is accepted
//   load       start request, accepted when load=1 and ready=1 (abort low)
//   abort      synchronous cancel of the packet in flight
//   ready      idle and able to accept load
//   tx_bit     current symbol bit
//   tx_strobe  one-cycle pulse in the first cycle of each symbol
//   tx_active  preamble or payload symbols are being emitted
//   done       one-cycle pulse after the last payload symbol completes
//
// All outputs come straight from flops.
module packet_serializer #(
   parameter int PACKET_SIZE   = 8,
   parameter int SYMBOL_CYCLES = 16,
   parameter int PREAMBLE_BITS = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [PACKET_SIZE-1:0] packet,
   input  logic                   load,
   input  logic                   abort,
   output logic                   ready,
   output logic                   tx_bit,
   output logic                   tx_strobe,
   output logic                   tx_active,
   output logic                   done
);

   // Timer counts 0..SYMBOL_CYCLES-1. The symbol counter counts 0..CNT_MAX-1
   // within whichever phase is running.
   localparam int TW      = (SYMBOL_CYCLES > 1) ? $clog2(SYMBOL_CYCLES) : 1;
   localparam int CNT_MAX = (PREAMBLE_BITS > PACKET_SIZE) ? PREAMBLE_BITS : PACKET_SIZE;
   localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [TW-1:0] TIMER_LAST = TW'(SYMBOL_CYCLES - 1);
   localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);
   localparam logic [CW-1:0] PRE_LAST   = CW'((PREAMBLE_BITS > 0) ? PREAMBLE_BITS - 1 : 0);
   localparam logic [CW-1:0] PAY_LAST   = CW'(PACKET_SIZE - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PREAMBLE = 2'd1,
      PAYLOAD  = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [PACKET_SIZE-1:0] shift_q, shift_d;
   logic [TW-1:0]          timer_q, timer_d;
   logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
   logic                   tx_bit_q, tx_bit_d;
   logic                   tx_strobe_q, tx_strobe_d;
   logic                   tx_active_q, tx_active_d;
   logic                   done_q, done_d;
   logic                   ready_q, ready_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         timer_q     <= '0;
         bit_cnt_q   <= '0;
         tx_bit_q    <= 1'b0;
         tx_strobe_q <= 1'b0;
         tx_active_q <= 1'b0;
         done_q      <= 1'b0;
         ready_q     <= 1'b1;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         timer_q     <= timer_d;
         bit_cnt_q   <= bit_cnt_d;
         tx_bit_q    <= tx_bit_d;
         tx_strobe_q <= tx_strobe_d;
         tx_active_q <= tx_active_d;
         done_q      <= done_d;
         ready_q     <= ready_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      timer_d     = timer_q;
      bit_cnt_d   = bit_cnt_q;
      tx_bit_d    = tx_bit_q;
      tx_strobe_d = 1'b0;
      tx_active_d = tx_active_q;
      done_d      = 1'b0;
      ready_d     = ready_q;

      case (state_q)
         IDLE: begin
            if (load && !abort) begin
               timer_d     = '0;
               bit_cnt_d   = '0;
               tx_strobe_d = 1'b1;
               tx_active_d = 1'b1;
               ready_d     = 1'b0;
               if (PREAMBLE_BITS > 0) begin
                  state_d  = PREAMBLE;
                  shift_d  = packet;
                  tx_bit_d = 1'b1;
               end else begin
                  // No preamble: the first payload bit goes out right away.
                  state_d  = PAYLOAD;
                  tx_bit_d = packet[PACKET_SIZE-1];
                  shift_d  = packet << 1;
               end
            end
         end

         PREAMBLE: begin
            if (timer_q == TIMER_LAST) begin
               timer_d     = '0;
               tx_strobe_d = 1'b1;
               if (bit_cnt_q == PRE_LAST) begin
                  state_d   = PAYLOAD;
                  bit_cnt_d = '0;
                  tx_bit_d  = shift_q[PACKET_SIZE-1];
                  shift_d   = shift_q << 1;
               end else begin
                  bit_cnt_d = bit_cnt_q + CNT_ONE;
                  tx_bit_d  = ~tx_bit_q;
               end
            end else begin
               timer_d = timer_q + TIMER_ONE;
            end
         end

         PAYLOAD: begin
            if (timer_q == TIMER_LAST) begin
               timer_d = '0;
               if (bit_cnt_q == PAY_LAST) begin
                  state_d     = IDLE;
                  bit_cnt_d   = '0;
                  tx_bit_d    = 1'b0;
                  tx_active_d = 1'b0;
                  ready_d     = 1'b1;
                  done_d      = 1'b1;
               end else begin
                  tx_strobe_d = 1'b1;
                  bit_cnt_d   = bit_cnt_q + CNT_ONE;
                  tx_bit_d    = shift_q[PACKET_SIZE-1];
                  shift_d     = shift_q << 1;
               end
            end else begin
               timer_d = timer_q + TIMER_ONE;
            end
         end

         default: begin
            state_d     = IDLE;
            tx_bit_d    = 1'b0;
            tx_active_d = 1'b0;
            ready_d     = 1'b1;
         end
      endcase

      // An abort cancels the packet in flight and suppresses the done pulse.
      if (abort && state_q != IDLE) begin
         state_d     = IDLE;
         timer_d     = '0;
         bit_cnt_d   = '0;
         tx_bit_d    = 1'b0;
         tx_strobe_d = 1'b0;
         tx_active_d = 1'b0;
         done_d      = 1'b0;
         ready_d     = 1'b1;
      end
   end

   assign ready     = ready_q;
   assign tx_bit    = tx_bit_q;
   assign tx_strobe = tx_strobe_q;
   assign tx_active = tx_active_q;
   assign done      = done_q;

endmodule

// File: tb/tb_packet_serializer.sv
module tb_packet_serializer;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [1:0][7:0] packet_v;
   logic [1:0]      load_v;
   logic [1:0]      abort_v;
   logic [1:0]      ready_v, tx_bit_v, tx_strobe_v, tx_active_v, done_v;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Instance 0: 4-cycle symbols with a 4-symbol preamble.
   packet_serializer #(.PACKET_SIZE(8), .SYMBOL_CYCLES(4), .PREAMBLE_BITS(4)) u_a (
      .clk       (clk),
      .rst       (rst),
      .packet    (packet_v[0]),
      .load      (load_v[0]),
      .abort     (abort_v[0]),
      .ready     (ready_v[0]),
      .tx_bit    (tx_bit_v[0]),
      .tx_strobe (tx_strobe_v[0]),
      .tx_active (tx_active_v[0]),
      .done      (done_v[0])
   );

   // Instance 1: 1-cycle symbols with no preamble.
   packet_serializer #(.PACKET_SIZE(8), .SYMBOL_CYCLES(1), .PREAMBLE_BITS(0)) u_b (
      .clk       (clk),
      .rst       (rst),
      .packet    (packet_v[1]),
      .load      (load_v[1]),
      .abort     (abort_v[1]),
      .ready     (ready_v[1]),
      .tx_bit    (tx_bit_v[1]),
      .tx_strobe (tx_strobe_v[1]),
      .tx_active (tx_active_v[1]),
      .done      (done_v[1])
   );

   task automatic chk(input string tag, input int d, input int k, input logic obs, input logic exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s dut=%0d step=%0d observed=%b expected=%b", tag, d, k, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag, input int d, input int k, input logic exp_done);
      chk({tag, "_ready"}, d, k, ready_v[d], 1'b1);
      chk({tag, "_active"}, d, k, tx_active_v[d], 1'b0);
      chk({tag, "_bit"}, d, k, tx_bit_v[d], 1'b0);
      chk({tag, "_strobe"}, d, k, tx_strobe_v[d], 1'b0);
      chk({tag, "_done"}, d, k, done_v[d], exp_done);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Sends one packet on DUT d and checks every cycle against the expected
   // symbol stream. Entered and left at 1 time unit after a rising edge.
   // abort_at>0: abort is seen at edge N+abort_at.
   // busy_at>=0: load of 0xFF is attempted after edge N+busy_at.
   // rst_at>=0: async reset pulse between edges after edge N+rst_at.
   task automatic send(input int d, input logic [7:0] pkt, input int abort_at,
                       input int busy_at, input int rst_at);
      int   sc, pre, nsym, t;
      logic sym [0:15];
      bit   cut;
      sc   = (d == 0) ? 4 : 1;
      pre  = (d == 0) ? 4 : 0;
      nsym = pre + 8;
      t    = nsym * sc;
      for (int i = 0; i < nsym; i++)
         sym[i] = (i < pre) ? ((i % 2) == 0) : pkt[7 - (i - pre)];
      cut = 1'b0;

      chk("pre_ready", d, -1, ready_v[d], 1'b1);
      load_v[d]   = 1'b1;
      packet_v[d] = pkt;
      tick();
      load_v[d]   = 1'b0;
      packet_v[d] = 8'($urandom);

      for (int k = 0; k < t && !cut; k++) begin
         chk("active", d, k, tx_active_v[d], 1'b1);
         chk("bit", d, k, tx_bit_v[d], sym[k / sc]);
         chk("strobe", d, k, tx_strobe_v[d], (k % sc) == 0);
         chk("busy_ready", d, k, ready_v[d], 1'b0);
         chk("busy_done", d, k, done_v[d], 1'b0);
         if (k == rst_at) begin
            #2 rst = 1'b1;
            #1 chk_idle("async_rst", d, k, 1'b0);
            tick();
            chk_idle("rst_held", d, k, 1'b0);
            #3 rst = 1'b0;
            tick();
            chk_idle("rst_release", d, k, 1'b0);
            cut = 1'b1;
         end else begin
            if (k == busy_at) begin
               load_v[d]   = 1'b1;
               packet_v[d] = 8'hFF;
            end
            if (abort_at > 0 && k == abort_at - 1) abort_v[d] = 1'b1;
            tick();
            load_v[d]  = 1'b0;
            if (abort_at > 0 && k == abort_at - 1) begin
               abort_v[d] = 1'b0;
               chk_idle("abort", d, k, 1'b0);
               tick();
               chk_idle("abort_after", d, k, 1'b0);
               cut = 1'b1;
            end
         end
      end
      if (!cut) chk_idle("complete", d, t, 1'b1);
      $display("packet dut=%0d data=%02h abort_at=%0d busy_at=%0d rst_at=%0d %s",
               d, pkt, abort_at, busy_at, rst_at, cut ? "cut short" : "completed");
   endtask

   initial begin
      logic [7:0] rp;
      int         rd, ra, rb;
      load_v   = '0;
      abort_v  = '0;
      packet_v = '0;

      // Async reset with no clock edge yet.
      #2 rst = 1'b1;
      #1;
      chk_idle("reset", 0, 0, 1'b0);
      chk_idle("reset", 1, 0, 1'b0);
      #8 rst = 1'b0;
      tick();
      chk_idle("post_reset", 0, 0, 1'b0);

      // Nominal packet, with a busy load attempted at cycle 10.
      send(0, 8'hA5, 0, 10, -1);
      tick();
      chk("done_one_cycle", 0, 0, done_v[0], 1'b0);

      // Abort during payload symbol 3, then a fresh packet.
      send(0, 8'hA5, (4 + 3) * 4 + 2, -1, -1);
      send(0, 8'h3C, 0, -1, -1);
      tick();

      // Abort together with load while idle: load must be rejected.
      abort_v[0] = 1'b1;
      load_v[0]  = 1'b1;
      packet_v[0] = 8'h55;
      tick();
      abort_v[0] = 1'b0;
      load_v[0]  = 1'b0;
      chk_idle("abort_load_idle", 0, 0, 1'b0);

      // Back-to-back with no preamble and 1-cycle symbols.
      send(1, 8'h81, 0, -1, -1);
      send(1, 8'h7E, 0, -1, -1);
      tick();

      // Async reset during preamble symbol 2.
      send(0, 8'hC3, 0, -1, 2 * 4 + 1);
      send(0, 8'h96, 0, -1, -1);
      tick();

      // Randomized packets with occasional aborts and busy loads.
      for (int n = 0; n < 8; n++) begin
         rd = int'($urandom_range(0, 1));
         rp = 8'($urandom);
         ra = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, (rd == 0) ? 47 : 7)) : 0;
         rb = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, (rd == 0) ? 40 : 6)) : -1;
         send(rd, rp, ra, rb, -1);
         if ($urandom_range(0, 1) == 0) tick();
      end
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach its end");
      $fatal(1, "timeout");
   end

endmodule
